// File: rtl/sliding_window_ctrl_pkg.sv
// sliding_window_ctrl_pkg: shared FSM state type and default geometry for the window controller.
// Rev 1.0
`default_nettype none

package sliding_window_ctrl_pkg;

  localparam int DEF_WORD_SIZE   = 8;
  localparam int DEF_BUFFER_SIZE = 3;
  localparam int DEF_ROW_SIZE    = 10;
  localparam int DEF_IMG_ROWS    = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } swc_state_t;

endpackage

`default_nettype wire

// File: rtl/sliding_window_ctrl_if.sv
// sliding_window_ctrl_if: pixel-in, line-buffer-out and window handshake bundle.
// Rev 1.0
`default_nettype none

interface sliding_window_ctrl_if
  import sliding_window_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ROW_SIZE  = DEF_ROW_SIZE,
  parameter int IMG_ROWS  = DEF_IMG_ROWS
);
  localparam int ROW_W = $clog2(IMG_ROWS);
  localparam int COL_W = $clog2(ROW_SIZE);

  logic                 start;
  logic                 abort;
  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] in_pixel;
  logic                 sw_shift_en;
  logic [WORD_SIZE-1:0] sw_pixel;
  logic                 sw_clear;
  logic                 win_valid;
  logic                 win_ready;
  logic [ROW_W-1:0]     win_row;
  logic [COL_W-1:0]     win_col;
  logic                 busy;
  logic                 frame_done;

  // master = pixel source / conv engine side, slave = controller
  modport master (
    output start, abort, in_valid, in_pixel, win_ready,
    input  in_ready, sw_shift_en, sw_pixel, sw_clear, win_valid,
           win_row, win_col, busy, frame_done
  );

  modport slave (
    input  start, abort, in_valid, in_pixel, win_ready,
    output in_ready, sw_shift_en, sw_pixel, sw_clear, win_valid,
           win_row, win_col, busy, frame_done
  );

endinterface

`default_nettype wire

// File: rtl/sliding_window_ctrl_pos_counter.sv
// sliding_window_ctrl_pos_counter: raster row/col position of the next pixel to accept.
// Rev 1.0
`default_nettype none

module sliding_window_ctrl_pos_counter
  import sliding_window_ctrl_pkg::*;
#(
  parameter int ROW_SIZE = DEF_ROW_SIZE,
  parameter int IMG_ROWS = DEF_IMG_ROWS,
  localparam int ROW_W   = $clog2(IMG_ROWS),
  localparam int COL_W   = $clog2(ROW_SIZE)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == COL_W'(ROW_SIZE - 1));
  assign row_end = (row == ROW_W'(IMG_ROWS - 1));
  assign last    = col_end && row_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sliding_window_ctrl.sv
// sliding_window_ctrl: sequences a KxK line buffer from a raster pixel stream and
// holds each complete window until the conv engine takes it. Rev 1.0
`default_nettype none

module sliding_window_ctrl
  import sliding_window_ctrl_pkg::*;
#(
  parameter int WORD_SIZE   = DEF_WORD_SIZE,
  parameter int ROW_SIZE    = DEF_ROW_SIZE,
  parameter int IMG_ROWS    = DEF_IMG_ROWS,
  parameter int BUFFER_SIZE = DEF_BUFFER_SIZE
)(
  input  logic                 clk,
  input  logic                 rst,
  sliding_window_ctrl_if.slave bus
);

  localparam int ROW_W = $clog2(IMG_ROWS);
  localparam int COL_W = $clog2(ROW_SIZE);

  swc_state_t           state;
  swc_state_t           state_next;
  logic                 clear_next;
  logic                 pending;
  logic                 in_ready;
  logic                 accept;
  logic                 abort_hit;
  logic                 last_px;
  logic                 win_hit;
  logic [ROW_W-1:0]     row;
  logic [COL_W-1:0]     col;

  logic                 sw_clear_q;
  logic                 sw_shift_q;
  logic [WORD_SIZE-1:0] sw_pixel_q;
  logic                 win_valid_q;
  logic [ROW_W-1:0]     win_row_q;
  logic [COL_W-1:0]     win_col_q;

  sliding_window_ctrl_pos_counter #(
    .ROW_SIZE (ROW_SIZE),
    .IMG_ROWS (IMG_ROWS)
  ) u_pos (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == CLEAR),
    .inc  (accept),
    .row  (row),
    .col  (col),
    .last (last_px)
  );

  assign abort_hit = bus.abort && (state != IDLE);
  assign pending   = win_valid_q && !bus.win_ready;
  // abort also blocks acceptance so no pixel lands in a buffer that is being cleared
  assign in_ready  = (state == STREAM) && !bus.abort && !pending;
  assign accept    = bus.in_valid && in_ready;
  assign win_hit   = (row >= ROW_W'(BUFFER_SIZE - 1)) && (col >= COL_W'(BUFFER_SIZE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear_next = 1'b0;
    if (abort_hit) begin
      state_next = IDLE;
      clear_next = 1'b1;
    end else begin
      case (state)
        IDLE:    if (bus.start && !bus.abort) begin
                   state_next = CLEAR;
                   clear_next = 1'b1;
                 end
        CLEAR:   state_next = STREAM;
        STREAM:  if (accept && last_px) state_next = DRAIN;
        DRAIN:   if (!pending) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_clear_q  <= 1'b0;
      sw_shift_q  <= 1'b0;
      sw_pixel_q  <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      sw_clear_q <= clear_next;
      sw_shift_q <= accept;
      if (accept) sw_pixel_q <= bus.in_pixel;
      // a newly completed window overrides the clear from a same-cycle consume
      if (abort_hit) begin
        win_valid_q <= 1'b0;
      end else if (accept && win_hit) begin
        win_valid_q <= 1'b1;
        win_row_q   <= row;
        win_col_q   <= col;
      end else if (win_valid_q && bus.win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.sw_shift_en = sw_shift_q;
  assign bus.sw_pixel    = sw_pixel_q;
  assign bus.sw_clear    = sw_clear_q;
  assign bus.win_valid   = win_valid_q;
  assign bus.win_row     = win_row_q;
  assign bus.win_col     = win_col_q;
  assign bus.busy        = (state != IDLE);
  assign bus.frame_done  = (state == DONE) && !bus.abort;

endmodule

`default_nettype wire

// File: tb/tb_sliding_window_ctrl.sv
// tb_sliding_window_ctrl: randomized frames against a raster-index reference model with
// a queue scoreboard; pixels and window positions are checked by an independent monitor.
`default_nettype none

module tb_sliding_window_ctrl;

  localparam int W    = 8;
  localparam int ROW  = 10;
  localparam int ROWS = 10;
  localparam int K    = 3;
  localparam int NWIN = (ROWS - K + 1) * (ROW - K + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  sliding_window_ctrl_if #(.WORD_SIZE(W), .ROW_SIZE(ROW), .IMG_ROWS(ROWS)) bus ();

  sliding_window_ctrl #(
    .WORD_SIZE   (W),
    .ROW_SIZE    (ROW),
    .IMG_ROWS    (ROWS),
    .BUFFER_SIZE (K)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int px_q[$];
  int win_q[$];
  int seen[$];
  int fd_cnt = 0;
  int wv_cycles = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a pixel or a consumed window.
  bit prev_pend  = 1'b0;
  bit prev_abort = 1'b0;
  int prev_row   = 0;
  int prev_col   = 0;

  always @(negedge clk) begin
    if (!rst) begin
      px_q.delete();
      win_q.delete();
      prev_pend  = 1'b0;
      prev_abort = 1'b0;
    end else begin
      if (bus.sw_shift_en) begin
        if (px_q.size() == 0) chk("unexpected_shift", 1, 0);
        else chk("sw_pixel", int'(bus.sw_pixel), px_q.pop_front());
      end
      if (prev_pend && !prev_abort) begin
        chk("hold_valid", int'(bus.win_valid), 1);
        chk("hold_row", int'(bus.win_row), prev_row);
        chk("hold_col", int'(bus.win_col), prev_col);
        chk("stall_no_shift", int'(bus.sw_shift_en), 0);
      end
      if (bus.win_valid) begin
        wv_cycles++;
        if (!bus.win_ready) chk("pending_in_ready", int'(bus.in_ready), 0);
      end
      if (bus.win_valid && bus.win_ready) begin
        if (win_q.size() == 0) chk("unexpected_window", 1, 0);
        else chk("win_pos", int'(bus.win_row) * 16 + int'(bus.win_col), win_q.pop_front());
        seen.push_back(int'(bus.win_row) * 16 + int'(bus.win_col));
      end
      if (bus.frame_done) fd_cnt++;
      if (!bus.busy) chk("idle_in_ready", int'(bus.in_ready), 0);
      prev_pend  = bus.win_valid && !bus.win_ready;
      prev_abort = bus.abort && bus.busy;
      prev_row   = int'(bus.win_row);
      prev_col   = int'(bus.win_col);
    end
  end

  // One stimulus cycle; on acceptance the reference model derives the raster position
  // from the accept index and queues the pixel and, if it completes a window, its position.
  task automatic drive_cycle(input bit v, input logic [W-1:0] px, input bit wr, inout int acc);
    @(posedge clk); #1;
    bus.in_valid  = v;
    bus.in_pixel  = px;
    bus.win_ready = wr;
    @(negedge clk);
    if (bus.in_valid && bus.in_ready) begin
      px_q.push_back(int'(px));
      if ((acc / ROW) >= K - 1 && (acc % ROW) >= K - 1)
        win_q.push_back((acc / ROW) * 16 + (acc % ROW));
      acc++;
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'hA5;
    #1;
    chk("clear_pulse", int'(bus.sw_clear), 1);
    chk("clear_busy", int'(bus.busy), 1);
    chk("clear_in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #1;
    chk("clear_one_cycle", int'(bus.sw_clear), 0);
  endtask

  task automatic run_frame(input int pv, input int pr, input bit idx_px, input bit stall_first,
                           input int start_at, input int abort_at, input bit check_wv);
    int  acc      = 0;
    int  fd0      = fd_cnt;
    int  ws0      = seen.size();
    int  wv0      = wv_cycles;
    int  cyc      = 0;
    int  stall    = 0;
    bit  released = !stall_first;
    bit  sdone    = 1'b0;
    bit  wr;
    logic [W-1:0] px;
    do_start();
    while (fd_cnt == fd0 && cyc < 4000) begin
      if (abort_at >= 0 && acc == abort_at) begin
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.win_ready = 1'b0;
        bus.abort     = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_clear", int'(bus.sw_clear), 1);
        chk("abort_win_valid", int'(bus.win_valid), 0);
        chk("abort_frame_done", int'(bus.frame_done), 0);
        px_q.delete();
        win_q.delete();
        repeat (3) @(posedge clk);
        chk("abort_no_done", fd_cnt - fd0, 0);
        return;
      end
      if (start_at >= 0 && acc == start_at && !sdone) bus.start = 1'b1;
      wr = released ? ($urandom_range(99) < pr) : 1'b0;
      px = idx_px ? W'(acc) : W'($urandom);
      drive_cycle($urandom_range(99) < pv, px, wr, acc);
      if (bus.start) begin
        bus.start = 1'b0;
        sdone     = 1'b1;
        chk("start_in_stream_clear", int'(bus.sw_clear), 0);
        chk("start_in_stream_busy", int'(bus.busy), 1);
      end
      if (!released && bus.win_valid) begin
        stall++;
        chk("stall_in_ready", int'(bus.in_ready), 0);
        if (stall == 6) begin
          chk("stall_row", int'(bus.win_row), 2);
          chk("stall_col", int'(bus.win_col), 2);
          chk("stall_accepts", acc, (K - 1) * ROW + K);
          released = 1'b1;
        end
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("frame_done_once", fd_cnt - fd0, 1);
    chk("frame_accepts", acc, ROW * ROWS);
    chk("frame_windows", seen.size() - ws0, NWIN);
    chk("px_q_empty", px_q.size(), 0);
    chk("win_q_empty", win_q.size(), 0);
    chk("frame_idle", int'(bus.busy), 0);
    if (check_wv) chk("win_valid_cycles", wv_cycles - wv0, NWIN);
    if (seen.size() > ws0) begin
      chk("first_window", seen[ws0], (K - 1) * 16 + (K - 1));
      chk("last_window", seen[seen.size() - 1], (ROWS - 1) * 16 + (ROW - 1));
    end
  endtask

  task automatic reset_test();
    int acc = 0;
    do_start();
    for (int i = 0; i < 30; i++) drive_cycle(1'b1, W'(acc + 1), 1'b0, acc);
    chk("pre_rst_busy", int'(bus.busy), 1);
    chk("pre_rst_win_valid", int'(bus.win_valid), 1);
    chk("pre_rst_accepts", acc, (K - 1) * ROW + K);
    @(posedge clk); #3;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_win_valid", int'(bus.win_valid), 0);
    chk("rst_win_row", int'(bus.win_row), 0);
    chk("rst_win_col", int'(bus.win_col), 0);
    chk("rst_sw_pixel", int'(bus.sw_pixel), 0);
    chk("rst_sw_shift", int'(bus.sw_shift_en), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.win_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_in_ready", int'(bus.in_ready), 0);
    chk("reset_sw_shift", int'(bus.sw_shift_en), 0);
    chk("reset_sw_clear", int'(bus.sw_clear), 0);
    chk("reset_win_valid", int'(bus.win_valid), 0);
    chk("reset_frame_done", int'(bus.frame_done), 0);
    @(negedge clk);
    rst = 1'b1;

    run_frame(100, 100, 1'b1, 1'b0, -1, -1, 1'b1);
    run_frame(100, 100, 1'b0, 1'b1, -1, -1, 1'b0);
    repeat (2) run_frame(60, 50, 1'b0, 1'b0, -1, -1, 1'b0);
    run_frame(80, 70, 1'b0, 1'b0, 40, -1, 1'b0);

    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #1;
    chk("abort_start_idle_busy", int'(bus.busy), 0);
    chk("abort_start_idle_clear", int'(bus.sw_clear), 0);

    run_frame(100, 100, 1'b0, 1'b0, -1, 37, 1'b0);
    run_frame(70, 70, 1'b0, 1'b0, -1, -1, 1'b0);

    reset_test();
    run_frame(100, 100, 1'b1, 1'b0, -1, -1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
